// File: rtl/paeth_call_driver.sv
// paeth_call_driver: issues a run of idx calls into the paeth kernel, collects
// returns into a result FIFO with credit-based flow control, and keeps a checksum.
module paeth_call_driver #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_go,
    input  logic [31:0]      cfg_base,
    input  logic [CNT_W-1:0] cfg_count,
    output logic             run_busy,
    output logic             run_done,
    output logic [31:0]      checksum,
    output logic             k_start,
    output logic [31:0]      k_idx,
    input  logic             k_busy,
    input  logic             k_done,
    output logic             k_stall,
    input  logic [31:0]      k_data,
    output logic             res_valid,
    output logic [31:0]      res_data,
    input  logic             res_ready
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_count, w_count_nxt;
    logic [CNT_W-1:0]  r_issued, w_issued_nxt;
    logic [CNT_W-1:0]  r_returned, w_returned_nxt;
    logic [CNT_W-1:0]  w_inflight_nxt;
    logic [31:0]       r_idx, w_idx_nxt;
    logic [31:0]       r_sum, w_sum_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_start, w_start_nxt;
    logic              r_stall, w_stall_nxt;
    logic              r_valid;
    logic [OCC_W-1:0]  r_occ, w_occ_nxt;
    logic [PTR_W-1:0]  r_wr, r_rd;
    logic [31:0]       r_mem [FIFO_DEPTH];
    logic              w_call, w_push, w_pop;

    assign run_busy  = r_busy;
    assign run_done  = r_done;
    assign checksum  = r_sum;
    assign k_start   = r_start;
    assign k_idx     = r_idx;
    assign k_stall   = r_stall;
    assign res_valid = r_valid;
    assign res_data  = r_mem[r_rd];

    // Handshake qualifiers; returns outside an active run are discarded.
    assign w_call = r_start && !k_busy;
    assign w_push = k_done && !r_stall && (r_state == ST_ISSUE || r_state == ST_DRAIN);
    assign w_pop  = r_valid && res_ready;

    // Next-state, counters, and next values of the registered outputs.
    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_issued_nxt   = r_issued;
        w_returned_nxt = r_returned;
        w_idx_nxt      = r_idx;
        w_sum_nxt      = r_sum;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;

        if (w_call) begin
            w_issued_nxt = r_issued + CNT_W'(1);
            w_idx_nxt    = r_idx + 32'd1;
        end
        if (w_push) begin
            w_returned_nxt = r_returned + CNT_W'(1);
            w_sum_nxt      = r_sum + k_data;
        end

        case (r_state)
            ST_IDLE: begin
                if (cfg_go) begin
                    w_count_nxt    = cfg_count;
                    w_issued_nxt   = '0;
                    w_returned_nxt = '0;
                    w_sum_nxt      = '0;
                    w_idx_nxt      = cfg_base;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = (cfg_count == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_issued_nxt == r_count) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (r_returned == r_count && r_occ == '0) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        w_occ_nxt      = r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
        w_inflight_nxt = w_issued_nxt - w_returned_nxt;
        // A call is offered only if its result already has a reserved FIFO slot.
        w_start_nxt    = (w_state_nxt == ST_ISSUE) && (w_issued_nxt != w_count_nxt) &&
                         ((32'(w_inflight_nxt) + 32'(w_occ_nxt)) < 32'(FIFO_DEPTH));
        // Back-pressure only when a full FIFO could actually receive another return.
        w_stall_nxt    = (w_occ_nxt == OCC_W'(FIFO_DEPTH)) && (w_inflight_nxt != '0);
    end

    // State, counters, pointers and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_issued   <= '0;
            r_returned <= '0;
            r_idx      <= '0;
            r_sum      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_start    <= 1'b0;
            r_stall    <= 1'b0;
            r_valid    <= 1'b0;
            r_occ      <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_issued   <= w_issued_nxt;
            r_returned <= w_returned_nxt;
            r_idx      <= w_idx_nxt;
            r_sum      <= w_sum_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_start    <= w_start_nxt;
            r_stall    <= w_stall_nxt;
            r_valid    <= (w_occ_nxt != '0);
            r_occ      <= w_occ_nxt;
            if (w_push) r_wr <= r_wr + PTR_W'(1);
            if (w_pop)  r_rd <= r_rd + PTR_W'(1);
        end
    end

    // Result storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr] <= k_data;
    end

endmodule
